// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces and classifies chute coins, buffers valid
// ones in a circular FIFO and hands them to the vending core one per enabled cycle.
module coin_acceptor #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sense,
  input  logic [2:0] size,
  input  logic       enable,
  output logic [1:0] deposit,
  output logic       reject,
  output logic       reject_bad,
  output logic [3:0] level,
  output logic [1:0] dbg_state
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_MEASURE    = 2'd1;
  localparam logic [1:0] S_WAIT_CLEAR = 2'd2;

  localparam logic [1:0] C_NONE    = 2'd0;
  localparam logic [1:0] C_NICKEL  = 2'd1;
  localparam logic [1:0] C_DIME    = 2'd2;
  localparam logic [1:0] C_QUARTER = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    size_q, size_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    level_q, level_d;
  logic [1:0]    deposit_q, deposit_d;
  logic          reject_q, reject_d;
  logic          reject_bad_q, reject_bad_d;

  logic          classify;
  logic          coin_valid;
  logic [1:0]    coin_code;
  logic          pop;
  logic          room;
  logic          push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Classifier: a coin is classified once, on the edge its size has been
  // seen SETTLE times in a row, then ignored until the sensor clears.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    classify = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sense) begin
          size_d = size;
          cnt_d  = 3'd1;
          if (SETTLE == 1) begin
            classify = 1'b1;
            state_d  = S_WAIT_CLEAR;
          end else begin
            state_d = S_MEASURE;
          end
        end
      end
      S_MEASURE: begin
        if (!sense) begin
          state_d = S_IDLE;
        end else if (size != size_q) begin
          size_d = size;
          cnt_d  = 3'd1;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_d == 3'(SETTLE)) begin
            classify = 1'b1;
            state_d  = S_WAIT_CLEAR;
          end
        end
      end
      S_WAIT_CLEAR: begin
        if (!sense) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    coin_valid = 1'b1;
    coin_code  = C_NONE;
    case (size_d)
      3'd1:    coin_code = C_DIME;
      3'd2:    coin_code = C_NICKEL;
      3'd3:    coin_code = C_QUARTER;
      default: coin_valid = 1'b0;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    pop          = enable && (level_q != 4'd0);
    room         = (level_q < 4'(DEPTH)) || pop;
    push         = classify && coin_valid && room;
    reject_d     = classify && (!coin_valid || !room);
    reject_bad_d = classify && !coin_valid;
    deposit_d    = pop ? mem_q[rd_ptr_q] : C_NONE;
    mem_d        = mem_q;
    if (push) mem_d[wr_ptr_q] = coin_code;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 4'd1;
    else if (pop && !push) level_d = level_q - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      size_q       <= 3'd0;
      cnt_q        <= 3'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= 4'd0;
      deposit_q    <= C_NONE;
      reject_q     <= 1'b0;
      reject_bad_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      deposit_q    <= deposit_d;
      reject_q     <= reject_d;
      reject_bad_q <= reject_bad_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign deposit    = deposit_q;
  assign reject     = reject_q;
  assign reject_bad = reject_bad_q;
  assign level      = level_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected output events are queued by the
// stimulus and matched by a monitor; occupancy and state are checked inline.
module tb_coin_acceptor;

  localparam int DEPTH  = 4;
  localparam int SETTLE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sense = 1'b0;
  logic [2:0] size  = 3'd0;
  logic       enable = 1'b0;
  logic [1:0] deposit;
  logic       reject;
  logic       reject_bad;
  logic [3:0] level;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Each entry is {reject, reject_bad, deposit}.
  logic [3:0] exp_q[$];

  coin_acceptor #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clock      (clock),
    .reset      (reset),
    .sense      (sense),
    .size       (size),
    .enable     (enable),
    .deposit    (deposit),
    .reject     (reject),
    .reject_bad (reject_bad),
    .level      (level),
    .dbg_state  (dbg_state)
  );

  always #5 clock = ~clock;

  // Monitor: every nonzero output cycle must match the next queued event.
  always @(negedge clock) begin
    if (!reset && (deposit != 2'd0 || reject || reject_bad)) begin
      logic [3:0] got;
      logic [3:0] want;
      got = {reject, reject_bad, deposit};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got=%b required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL output_event got=%b required=%b", got, want);
        end
      end
    end
  end

  task automatic expect_out(input logic r, input logic rb, input logic [1:0] d);
    exp_q.push_back({r, rb, d});
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic coin(input logic [2:0] sz);
    sense = 1'b1;
    size  = sz;
    cyc(SETTLE);
    sense = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(2);
    reset = 1'b0;
    check("reset_level", level, 4'd0);
    check("reset_deposit", {2'b0, deposit}, 4'd0);
    check("reset_reject", {3'b0, reject}, 4'd0);
    check("reset_reject_bad", {3'b0, reject_bad}, 4'd0);
    check("reset_state", {2'b0, dbg_state}, 4'd0);

    // Single quarter, popped on the edge after it is classified.
    enable = 1'b1;
    expect_out(1'b0, 1'b0, 2'd3);
    sense = 1'b1; size = 3'd3;
    cyc(1); check("single_e1_level", level, 4'd0);
    cyc(1); check("single_e2_level", level, 4'd0);
    cyc(1); check("single_classify_level", level, 4'd1);
    cyc(1); check("single_pop_level", level, 4'd0);
    sense = 1'b0;
    cyc(1);

    // Glitch: two sense samples then release.
    sense = 1'b1; size = 3'd3;
    cyc(2);
    sense = 1'b0;
    cyc(1);
    check("glitch_level", level, 4'd0);
    check("glitch_state", {2'b0, dbg_state}, 4'd0);

    // Unstable size 2,2,1,1,1: dime only after three consecutive 1s.
    expect_out(1'b0, 1'b0, 2'd2);
    sense = 1'b1; size = 3'd2;
    cyc(2);
    size = 3'd1;
    cyc(2); check("unstable_no_push", level, 4'd0);
    cyc(1); check("unstable_classify", level, 4'd1);
    sense = 1'b0;
    cyc(1); check("unstable_pop", level, 4'd0);

    // Invalid size.
    expect_out(1'b1, 1'b1, 2'd0);
    sense = 1'b1; size = 3'd5;
    cyc(3); check("invalid_level", level, 4'd0);
    sense = 1'b0;
    cyc(1); check("invalid_pulse_ends", {3'b0, reject}, 4'd0);

    // Overflow with enable low, then drain.
    enable = 1'b0;
    coin(3'd2); coin(3'd1); coin(3'd3); coin(3'd2);
    check("overflow_full", level, 4'd4);
    expect_out(1'b1, 1'b0, 2'd0);
    coin(3'd1);
    check("overflow_level", level, 4'd4);
    expect_out(1'b0, 1'b0, 2'd1);
    expect_out(1'b0, 1'b0, 2'd2);
    expect_out(1'b0, 1'b0, 2'd3);
    expect_out(1'b0, 1'b0, 2'd1);
    enable = 1'b1;
    cyc(4); check("drain_level", level, 4'd0);
    cyc(1); check("drain_deposit_none", {2'b0, deposit}, 4'd0);
    enable = 1'b0;

    // Full FIFO, push and pop on the same classify edge, across the wrap.
    coin(3'd3); coin(3'd2); coin(3'd1); coin(3'd3);
    check("full_level", level, 4'd4);
    expect_out(1'b0, 1'b0, 2'd3);
    expect_out(1'b0, 1'b0, 2'd1);
    expect_out(1'b0, 1'b0, 2'd2);
    expect_out(1'b0, 1'b0, 2'd3);
    expect_out(1'b0, 1'b0, 2'd1);
    sense = 1'b1; size = 3'd2;
    cyc(2);
    enable = 1'b1;
    cyc(1);
    check("simul_level", level, 4'd4);
    check("simul_no_reject", {3'b0, reject}, 4'd0);
    sense = 1'b0;
    cyc(4); check("simul_drained", level, 4'd0);
    enable = 1'b0;

    // Reset with three coins buffered and a measurement in progress.
    coin(3'd1); coin(3'd2); coin(3'd3);
    check("pre_reset_level", level, 4'd3);
    sense = 1'b1; size = 3'd3;
    cyc(1); check("pre_reset_state", {2'b0, dbg_state}, 4'd1);
    reset = 1'b1; sense = 1'b0;
    cyc(1);
    reset = 1'b0;
    check("mid_reset_level", level, 4'd0);
    check("mid_reset_deposit", {2'b0, deposit}, 4'd0);
    check("mid_reset_reject", {3'b0, reject}, 4'd0);
    check("mid_reset_state", {2'b0, dbg_state}, 4'd0);
    enable = 1'b1;
    expect_out(1'b0, 1'b0, 2'd3);
    coin(3'd3);
    check("post_reset_level", level, 4'd0);
    enable = 1'b0;

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs got=%0d pending required=0", exp_q.size());
    end
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
